// File: rtl/kutula_if.sv
// Pizza intake (from pisir) and courier delivery signals of the packaging stage.
interface kutula_if;
  logic basla;
  logic kabarik;
  logic tuzlu;
  logic kurye_hazir;
  logic teslim_gecerli;
  logic teslim_kabarik;
  logic teslim_tuzlu;

  modport master (
    output basla, kabarik, tuzlu, kurye_hazir,
    input  teslim_gecerli, teslim_kabarik, teslim_tuzlu
  );

  modport slave (
    input  basla, kabarik, tuzlu, kurye_hazir,
    output teslim_gecerli, teslim_kabarik, teslim_tuzlu
  );
endinterface

// File: rtl/kutula.sv
// Packaging stage: buffers baked pizzas, folds a box for each, hands it to the courier.
module kutula #(
  parameter int DERINLIK       = 4,
  parameter int KATLAMA_SURESI = 3
) (
  input  logic       saat,
  input  logic       reset,
  kutula_if.slave    pz,
  output logic [6:0] kutu_sayisi,
  output logic [3:0] kayip_sayisi,
  output logic       dolu,
  output logic       bos,
  output logic       bitti
);
  localparam int AW = $clog2(DERINLIK);
  localparam int CW = $clog2(DERINLIK) + 1;
  localparam int SW = $clog2(KATLAMA_SURESI + 1);

  typedef enum logic [1:0] {BOSTA, KATLA, TESLIM} durum_t;

  durum_t        durum_q, durum_d;
  logic [1:0]    mem [DERINLIK];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] doluluk, doluluk_d;
  logic [SW-1:0] sayac;
  logic [1:0]    calisma;
  logic          gecerli_q, kabarik_q, tuzlu_q;
  logic          push, drop, pop, yukle, el_sikisma;

  assign pz.teslim_gecerli = gecerli_q;
  assign pz.teslim_kabarik = kabarik_q;
  assign pz.teslim_tuzlu   = tuzlu_q;

  // Full is judged on pre-edge occupancy, so a same-edge pop never rescues a push.
  assign push      = pz.basla && (doluluk != CW'(DERINLIK));
  assign drop      = pz.basla && (doluluk == CW'(DERINLIK));
  assign doluluk_d = doluluk + CW'(push) - CW'(pop);

  always_comb begin
    durum_d    = durum_q;
    pop        = 1'b0;
    yukle      = 1'b0;
    el_sikisma = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (doluluk != '0) begin
          pop     = 1'b1;
          durum_d = KATLA;
        end
      end
      KATLA: begin
        if (sayac == SW'(KATLAMA_SURESI - 1)) begin
          yukle   = 1'b1;
          durum_d = TESLIM;
        end
      end
      TESLIM: begin
        if (pz.kurye_hazir) begin
          el_sikisma = 1'b1;
          durum_d    = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      durum_q      <= BOSTA;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      doluluk      <= '0;
      sayac        <= '0;
      calisma      <= '0;
      gecerli_q    <= 1'b0;
      kabarik_q    <= 1'b0;
      tuzlu_q      <= 1'b0;
      kutu_sayisi  <= '0;
      kayip_sayisi <= '0;
      dolu         <= 1'b0;
      bos          <= 1'b1;
      bitti        <= 1'b0;
    end else begin
      durum_q <= durum_d;
      doluluk <= doluluk_d;
      dolu    <= (doluluk_d == CW'(DERINLIK));
      bos     <= (doluluk_d == '0);
      bitti   <= el_sikisma;

      if (push) begin
        mem[wr_ptr] <= {pz.kabarik, pz.tuzlu};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (drop && kayip_sayisi != '1)
        kayip_sayisi <= kayip_sayisi + 4'd1;

      if (pop) begin
        calisma <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
        sayac   <= '0;
      end else if (durum_q == KATLA) begin
        sayac <= sayac + SW'(1);
      end

      if (yukle) begin
        gecerli_q <= 1'b1;
        kabarik_q <= calisma[1];
        tuzlu_q   <= calisma[0];
      end else if (el_sikisma) begin
        gecerli_q <= 1'b0;
        if (kutu_sayisi != '1)
          kutu_sayisi <= kutu_sayisi + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_kutula.sv
// Directed self-checking bench for the kutula packaging stage (DERINLIK=4, KATLAMA_SURESI=3).
module tb_kutula;
  logic       saat = 1'b0;
  logic       reset;
  logic [6:0] kutu_sayisi;
  logic [3:0] kayip_sayisi;
  logic       dolu, bos, bitti;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] got [0:31];
  int         got_n;

  kutula_if pz();

  kutula #(.DERINLIK(4), .KATLAMA_SURESI(3)) dut (
    .saat(saat), .reset(reset), .pz(pz),
    .kutu_sayisi(kutu_sayisi), .kayip_sayisi(kayip_sayisi),
    .dolu(dolu), .bos(bos), .bitti(bitti)
  );

  always #5 saat = ~saat;

  task automatic tick;
    @(posedge saat);
    #1;
  endtask

  task automatic do_reset;
    pz.basla = 1'b0; pz.kabarik = 1'b0; pz.tuzlu = 1'b0; pz.kurye_hazir = 1'b0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic push(input logic [1:0] v);
    pz.basla = 1'b1;
    {pz.kabarik, pz.tuzlu} = v;
    tick;
    pz.basla = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pz.teslim_gecerli) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic drain(input int n, input int budget);
    got_n = 0;
    pz.kurye_hazir = 1'b1;
    for (int i = 0; i < budget && got_n < n; i++) begin
      if (pz.teslim_gecerli) begin
        got[got_n] = {pz.teslim_kabarik, pz.teslim_tuzlu};
        got_n++;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    logic [16:0] obs;
    logic [16:0] exp;
    do_reset;
    obs = {pz.teslim_gecerli, pz.teslim_kabarik, pz.teslim_tuzlu, kutu_sayisi, kayip_sayisi, dolu, bos, bitti};
    exp = {1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_state: got %h want %h", obs, exp); end
  endtask

  task automatic test_single;
    do_reset;
    pz.kurye_hazir = 1'b1;
    push(2'b10);
    for (int i = 1; i <= 3; i++) begin
      tick;
      n_cmp++;
      if (pz.teslim_gecerli !== 1'b0) begin n_err++; $display("FAIL single_early_valid(+%0d): got %b want 0", i, pz.teslim_gecerli); end
    end
    tick;
    n_cmp++;
    if ({pz.teslim_gecerli, pz.teslim_kabarik, pz.teslim_tuzlu} !== 3'b110) begin
      n_err++; $display("FAIL single_present: got %b want 110", {pz.teslim_gecerli, pz.teslim_kabarik, pz.teslim_tuzlu});
    end
    tick;
    n_cmp++;
    if ({pz.teslim_gecerli, bitti, kutu_sayisi} !== {1'b0, 1'b1, 7'd1}) begin
      n_err++; $display("FAIL single_handshake: got v=%b bitti=%b kutu=%0d want v=0 bitti=1 kutu=1", pz.teslim_gecerli, bitti, kutu_sayisi);
    end
    tick;
    n_cmp++;
    if (bitti !== 1'b0) begin n_err++; $display("FAIL single_bitti_width: got %b want 0", bitti); end
  endtask

  task automatic test_backpressure;
    logic [1:0] v [0:5];
    v[0] = 2'b10; v[1] = 2'b01; v[2] = 2'b11; v[3] = 2'b00; v[4] = 2'b10; v[5] = 2'b11;
    do_reset;
    for (int i = 0; i < 6; i++) begin
      push(v[i]);
      tick;
    end
    n_cmp++;
    if ({dolu, bos, kayip_sayisi, pz.teslim_gecerli} !== {1'b1, 1'b0, 4'd1, 1'b1}) begin
      n_err++; $display("FAIL bp_full: got dolu=%b bos=%b kayip=%0d v=%b want 1 0 1 1", dolu, bos, kayip_sayisi, pz.teslim_gecerli);
    end
    drain(5, 100);
    n_cmp++;
    if (got_n !== 5) begin n_err++; $display("FAIL bp_count: got %0d want 5", got_n); end
    for (int i = 0; i < 5 && i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== v[i]) begin n_err++; $display("FAIL bp_order[%0d]: got %b want %b", i, got[i], v[i]); end
    end
    n_cmp++;
    if ({kutu_sayisi, bos, pz.teslim_gecerli} !== {7'd5, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL bp_done: got kutu=%0d bos=%b v=%b want 5 1 0", kutu_sayisi, bos, pz.teslim_gecerli);
    end
    pz.kurye_hazir = 1'b0;
  endtask

  task automatic test_simultaneous;
    bit ok;
    logic [1:0] v [0:5];
    v[0] = 2'b11; v[1] = 2'b01; v[2] = 2'b10; v[3] = 2'b00; v[4] = 2'b11; v[5] = 2'b01;
    do_reset;
    push(v[0]);
    tick;
    push(v[1]);
    push(v[2]);
    wait_valid(20, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL sim_wait_valid: got timeout want valid"); end
    pz.kurye_hazir = 1'b1;
    tick;
    pz.kurye_hazir = 1'b0;
    push(v[3]);
    n_cmp++;
    if ({dolu, bos, kayip_sayisi} !== {1'b0, 1'b0, 4'd0}) begin
      n_err++; $display("FAIL sim_pushpop: got dolu=%b bos=%b kayip=%0d want 0 0 0", dolu, bos, kayip_sayisi);
    end
    push(v[4]);
    n_cmp++;
    if (dolu !== 1'b0) begin n_err++; $display("FAIL sim_occ3: got dolu=%b want 0", dolu); end
    push(v[5]);
    n_cmp++;
    if ({dolu, kayip_sayisi} !== {1'b1, 4'd0}) begin
      n_err++; $display("FAIL sim_occ4: got dolu=%b kayip=%0d want 1 0", dolu, kayip_sayisi);
    end
    drain(5, 100);
    n_cmp++;
    if (got_n !== 5) begin n_err++; $display("FAIL sim_count: got %0d want 5", got_n); end
    for (int i = 0; i < 5 && i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== v[i+1]) begin n_err++; $display("FAIL sim_order[%0d]: got %b want %b", i, got[i], v[i+1]); end
    end
    n_cmp++;
    if (kutu_sayisi !== 7'd6) begin n_err++; $display("FAIL sim_kutu: got %0d want 6", kutu_sayisi); end
    pz.kurye_hazir = 1'b0;
  endtask

  task automatic test_toggle_ready;
    bit ok;
    do_reset;
    push(2'b01);
    wait_valid(20, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL tog_wait_valid: got timeout want valid"); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if ({pz.teslim_gecerli, pz.teslim_kabarik, pz.teslim_tuzlu, kutu_sayisi} !== {3'b101, 7'd0}) begin
        n_err++; $display("FAIL tog_hold[%0d]: got v/k/t=%b%b%b kutu=%0d want 101 0", i,
                          pz.teslim_gecerli, pz.teslim_kabarik, pz.teslim_tuzlu, kutu_sayisi);
      end
    end
    pz.kurye_hazir = 1'b1;
    tick;
    n_cmp++;
    if ({pz.teslim_gecerli, kutu_sayisi, bitti} !== {1'b0, 7'd1, 1'b1}) begin
      n_err++; $display("FAIL tog_handshake: got v=%b kutu=%0d bitti=%b want 0 1 1", pz.teslim_gecerli, kutu_sayisi, bitti);
    end
    for (int i = 0; i < 4; i++) begin
      pz.kurye_hazir = i[0];
      tick;
    end
    n_cmp++;
    if ({kutu_sayisi, bitti} !== {7'd1, 1'b0}) begin
      n_err++; $display("FAIL tog_once: got kutu=%0d bitti=%b want 1 0", kutu_sayisi, bitti);
    end
    pz.kurye_hazir = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    pz.kurye_hazir = 1'b0;
    push(2'b11);
    push(2'b10);
    push(2'b01);
    push(2'b00);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_cmp++;
    if ({pz.teslim_gecerli, pz.teslim_kabarik, pz.teslim_tuzlu, kutu_sayisi, kayip_sayisi, dolu, bos, bitti}
        !== {3'b000, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL midreset_state: got v=%b kutu=%0d kayip=%0d dolu=%b bos=%b bitti=%b want 0 0 0 0 1 0",
                        pz.teslim_gecerli, kutu_sayisi, kayip_sayisi, dolu, bos, bitti);
    end
    tick;
    n_cmp++;
    if ({pz.teslim_gecerli, bos, bitti} !== 3'b010) begin
      n_err++; $display("FAIL midreset_idle: got v=%b bos=%b bitti=%b want 0 1 0", pz.teslim_gecerli, bos, bitti);
    end
    pz.kurye_hazir = 1'b1;
    push(2'b10);
    tick; tick; tick;
    n_cmp++;
    if (pz.teslim_gecerli !== 1'b0) begin n_err++; $display("FAIL midreset_early: got %b want 0", pz.teslim_gecerli); end
    tick;
    n_cmp++;
    if ({pz.teslim_gecerli, pz.teslim_kabarik, pz.teslim_tuzlu} !== 3'b110) begin
      n_err++; $display("FAIL midreset_present: got %b want 110", {pz.teslim_gecerli, pz.teslim_kabarik, pz.teslim_tuzlu});
    end
    tick;
    n_cmp++;
    if ({kutu_sayisi, bitti} !== {7'd1, 1'b1}) begin
      n_err++; $display("FAIL midreset_handshake: got kutu=%0d bitti=%b want 1 1", kutu_sayisi, bitti);
    end
    pz.kurye_hazir = 1'b0;
  endtask

  task automatic test_saturation;
    int seen;
    do_reset;
    pz.kurye_hazir = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      push({n[0], n[1]});
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
        if (bitti) seen = 1;
        else tick;
      end
      if (n == 1 || n == 127 || n == 130) begin
        n_cmp++;
        if (seen != 1) begin n_err++; $display("FAIL sat_delivery[%0d]: got timeout want bitti", n); end
      end
      if (n == 126) begin
        n_cmp++;
        if (kutu_sayisi !== 7'd126) begin n_err++; $display("FAIL sat_kutu126: got %0d want 126", kutu_sayisi); end
      end
      if (n == 127) begin
        n_cmp++;
        if (kutu_sayisi !== 7'd127) begin n_err++; $display("FAIL sat_kutu127: got %0d want 127", kutu_sayisi); end
      end
    end
    n_cmp++;
    if (kutu_sayisi !== 7'd127) begin n_err++; $display("FAIL sat_kutu_hold: got %0d want 127", kutu_sayisi); end
    pz.kurye_hazir = 1'b0;
    tick;
    // 25 back-to-back pizzas: one goes to folding, four fill the FIFO, twenty are dropped.
    for (int i = 0; i < 25; i++) begin
      push(2'b01);
      if (i == 18) begin
        n_cmp++;
        if (kayip_sayisi !== 4'd14) begin n_err++; $display("FAIL sat_kayip14: got %0d want 14", kayip_sayisi); end
      end
    end
    n_cmp++;
    if ({kayip_sayisi, dolu} !== {4'd15, 1'b1}) begin
      n_err++; $display("FAIL sat_kayip_hold: got kayip=%0d dolu=%b want 15 1", kayip_sayisi, dolu);
    end
  endtask

  initial begin
    reset = 1'b1;
    pz.basla = 1'b0; pz.kabarik = 1'b0; pz.tuzlu = 1'b0; pz.kurye_hazir = 1'b0;
    test_reset;
    test_single;
    test_backpressure;
    test_simultaneous;
    test_toggle_ready;
    test_reset_mid;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
